// File: rtl/ising_axi_regs.sv
// AXI4-Lite register front end for the N x N coupled-cell array: cell weight
// programming strobes, read-back, oscillator reset control and a run-cycle counter.
module ising_axi_regs #(
  parameter int N           = 8,
  parameter int NUM_WEIGHTS = 15
) (
  input  logic                clk,
  input  logic                axi_rstn,
  input  logic [11:0]         s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [31:0]         s_wdata,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [11:0]         s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [31:0]         s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                cell_wready,
  output logic [N*N-1:0]      cell_wr_addr_match,
  output logic [31:0]         cell_wdata,
  input  logic [32*N*N-1:0]   cell_rdata,
  output logic                ising_rstn
);
  localparam int NC = N * N;
  localparam logic [9:0]    WORD_CTRL   = 10'd0;
  localparam logic [9:0]    WORD_RUNCNT = 10'd1;
  localparam logic [9:0]    WORD_WBASE  = 10'd64;
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [31:0]   WEIGHT_MAX  = 32'(NUM_WEIGHTS - 1);
  localparam logic [NC-1:0] CELL_ONE    = NC'(1'b1);

  typedef enum logic [1:0] {SEL_CTRL = 2'd0, SEL_RUNCNT = 2'd1, SEL_WEIGHT = 2'd2, SEL_NONE = 2'd3} sel_e;

  function automatic sel_e decode(input logic [9:0] word);
    sel_e sel;
    if (word == WORD_CTRL) sel = SEL_CTRL;
    else if (word == WORD_RUNCNT) sel = SEL_RUNCNT;
    else if ((word >= WORD_WBASE) && (word < WORD_WBASE + 10'(NC))) sel = SEL_WEIGHT;
    else sel = SEL_NONE;
    return sel;
  endfunction

  function automatic logic [31:0] cell_slice(input logic [32*NC-1:0] bus, input logic [9:0] idx);
    logic [31:0] val;
    val = 32'd0;
    for (int k = 0; k < NC; k++) begin
      if (idx == 10'(k)) val = bus[32*k +: 32];
    end
    return val;
  endfunction

  logic [9:0]  aw_word_r;
  logic [31:0] w_data_r;
  logic        aw_held_r, w_held_r, exec_r, done_r;
  logic [31:0] runcnt_r;
  sel_e        wr_sel_s, rd_sel_s;
  logic [9:0]  wr_idx_s;
  logic        wr_ok_s, ctrl_wr_s;
  logic [1:0]  wr_resp_s, rd_resp_s;
  logic [31:0] rd_data_s;
  logic        aw_take_s, w_take_s, b_hs_s, exec_start_s, ar_take_s, r_hs_s;
  logic        unused_s;

  assign aw_take_s    = s_awvalid && s_awready;
  assign w_take_s     = s_wvalid && s_wready;
  assign b_hs_s       = s_bvalid && s_bready;
  assign exec_start_s = aw_held_r && w_held_r && !done_r;
  assign ar_take_s    = s_arvalid && s_arready;
  assign r_hs_s       = s_rvalid && s_rready;
  assign ctrl_wr_s    = exec_r && (wr_sel_s == SEL_CTRL);
  assign unused_s     = ^{s_awaddr[1:0], s_araddr[1:0]};

  // Decode of the held write: weights are only programmable while the array is held.
  always_comb begin
    wr_sel_s = decode(aw_word_r);
    wr_idx_s = aw_word_r - WORD_WBASE;
    wr_ok_s  = (wr_sel_s == SEL_WEIGHT) && (w_data_r <= WEIGHT_MAX) && !ising_rstn;
    case (wr_sel_s)
      SEL_CTRL:   wr_resp_s = RESP_OKAY;
      SEL_WEIGHT: wr_resp_s = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      default:    wr_resp_s = RESP_SLVERR;
    endcase
  end

  // Write channel: independent AW/W capture, one EXEC cycle, then B until accepted.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_word_r <= 10'd0;
      w_data_r  <= 32'd0;
      exec_r    <= 1'b0;
      done_r    <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      cell_wready        <= 1'b0;
      cell_wr_addr_match <= {NC{1'b0}};
      cell_wdata         <= 32'd0;
    end else begin
      if (b_hs_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        done_r    <= 1'b0;
        s_bvalid  <= 1'b0;
        s_bresp   <= RESP_OKAY;
      end else begin
        if (aw_take_s) begin
          aw_held_r <= 1'b1;
          aw_word_r <= s_awaddr[11:2];
        end
        if (w_take_s) begin
          w_held_r <= 1'b1;
          w_data_r <= s_wdata;
        end
        if (exec_start_s) done_r <= 1'b1;
        if (exec_r) begin
          s_bvalid <= 1'b1;
          s_bresp  <= wr_resp_s;
        end
      end
      exec_r    <= exec_start_s;
      s_awready <= b_hs_s || (!(aw_held_r || aw_take_s) && !(s_bvalid || exec_r));
      s_wready  <= b_hs_s || (!(w_held_r || w_take_s) && !(s_bvalid || exec_r));
      cell_wready        <= exec_start_s && wr_ok_s;
      cell_wr_addr_match <= (exec_start_s && wr_ok_s) ? (CELL_ONE << wr_idx_s) : {NC{1'b0}};
      cell_wdata         <= (exec_start_s && wr_ok_s) ? w_data_r : 32'd0;
    end
  end

  // Oscillator hold control and saturating run counter (cleared on a 0->1 start).
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      ising_rstn <= 1'b0;
      runcnt_r   <= 32'd0;
    end else begin
      if (ctrl_wr_s) ising_rstn <= w_data_r[0];
      if (ctrl_wr_s && w_data_r[0] && !ising_rstn) runcnt_r <= 32'd0;
      else if (ising_rstn && (runcnt_r != 32'hFFFF_FFFF)) runcnt_r <= runcnt_r + 32'd1;
    end
  end

  // Read data mux evaluated against the pre-write register state.
  always_comb begin
    rd_sel_s  = decode(s_araddr[11:2]);
    rd_data_s = 32'd0;
    rd_resp_s = RESP_OKAY;
    case (rd_sel_s)
      SEL_CTRL:   rd_data_s = {31'd0, ising_rstn};
      SEL_RUNCNT: rd_data_s = runcnt_r;
      SEL_WEIGHT: rd_data_s = cell_slice(cell_rdata, s_araddr[11:2] - WORD_WBASE);
      default: begin
        rd_data_s = 32'd0;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Read channel: data registered at the AR handshake, held until accepted.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= 32'd0;
      s_rresp   <= RESP_OKAY;
    end else if (ar_take_s) begin
      s_arready <= 1'b0;
      s_rvalid  <= 1'b1;
      s_rdata   <= rd_data_s;
      s_rresp   <= rd_resp_s;
    end else if (r_hs_s) begin
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
    end else begin
      s_arready <= !s_rvalid;
    end
  end
endmodule

// File: tb/tb_ising_axi_regs.sv
// Scoreboard bench for ising_axi_regs: expected B/R responses and cell strobes
// are queued when stimulus is driven and checked when the DUT produces them.
module tb_ising_axi_regs;
  localparam int N  = 8;
  localparam int NC = N * N;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic axi_rstn = 1'b0;
  logic [11:0] s_awaddr = 12'd0, s_araddr = 12'd0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b1, s_arvalid = 1'b0, s_rready = 1'b1;
  logic [31:0] s_wdata = 32'd0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, cell_wready, ising_rstn;
  logic [1:0] s_bresp, s_rresp;
  logic [31:0] s_rdata, cell_wdata;
  logic [NC-1:0] cell_wr_addr_match;
  logic [32*NC-1:0] cell_rdata;

  typedef struct { logic [31:0] lo; logic [31:0] hi; logic [1:0] resp; } rexp_t;
  typedef struct { int idx; logic [31:0] data; } sexp_t;
  logic [1:0] b_exp_q[$];
  rexp_t r_exp_q[$];
  sexp_t s_exp_q[$];
  sexp_t se;
  rexp_t re;
  logic [1:0] be;
  int total = 0, bad = 0, cyc = 0, cyc_on = 0, cyc_off = 0, held = 0;

  ising_axi_regs #(.N(N), .NUM_WEIGHTS(15)) dut (
    .clk(clk), .axi_rstn(axi_rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cell_wready(cell_wready), .cell_wr_addr_match(cell_wr_addr_match),
    .cell_wdata(cell_wdata), .cell_rdata(cell_rdata), .ising_rstn(ising_rstn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_slice(input int k);
    return 32'hA500_0000 + 32'(k) * 32'h0001_0003;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    if (cell_wready) begin
      check("strobe_expected", 64'(s_exp_q.size() != 0), 64'd1);
      if (s_exp_q.size() != 0) begin
        se = s_exp_q.pop_front();
        check("strobe_match", cell_wr_addr_match, 64'd1 << se.idx);
        check("strobe_data", {32'd0, cell_wdata}, {32'd0, se.data});
      end
    end else begin
      check("idle_cell_bus", cell_wr_addr_match | {32'd0, cell_wdata}, 64'd0);
    end
    if (s_bvalid && s_bready) begin
      check("b_expected", 64'(b_exp_q.size() != 0), 64'd1);
      if (b_exp_q.size() != 0) begin
        be = b_exp_q.pop_front();
        check("bresp", {62'd0, s_bresp}, {62'd0, be});
      end
    end
    if (s_rvalid && s_rready) begin
      check("r_expected", 64'(r_exp_q.size() != 0), 64'd1);
      if (r_exp_q.size() != 0) begin
        re = r_exp_q.pop_front();
        check("rresp", {62'd0, s_rresp}, {62'd0, re.resp});
        if (re.lo == re.hi) check("rdata", {32'd0, s_rdata}, {32'd0, re.lo});
        else check("rdata_range", 64'((s_rdata >= re.lo) && (s_rdata <= re.hi)), 64'd1);
      end
    end
  end

  task automatic send_aw_w(input logic [11:0] addr, input logic [31:0] data);
    int n;
    logic aw_ok, w_ok;
    s_awaddr = addr; s_wdata = data; s_awvalid = 1'b1; s_wvalid = 1'b1; n = 0;
    while ((s_awvalid || s_wvalid) && n < 50) begin
      @(negedge clk);
      aw_ok = s_awready; w_ok = s_wready;
      @(posedge clk); #1;
      if (aw_ok) s_awvalid = 1'b0;
      if (w_ok) s_wvalid = 1'b0;
      n++;
    end
    check("aw_w_accept", {62'd0, s_awvalid, s_wvalid}, 64'd0);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_bvalid && s_bready) && n < 50);
    @(posedge clk); #1;
    check("b_arrived", 64'(n < 50), 64'd1);
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input bit strobe);
    sexp_t t;
    b_exp_q.push_back(resp);
    if (strobe) begin
      t.idx = int'((addr - 12'h100) >> 2);
      t.data = data;
      s_exp_q.push_back(t);
    end
    send_aw_w(addr, data);
    wait_b();
  endtask

  task automatic axi_read(input logic [11:0] addr, input logic [31:0] lo,
                          input logic [31:0] hi, input logic [1:0] resp);
    rexp_t t;
    int n;
    logic ar_ok;
    t.lo = lo; t.hi = hi; t.resp = resp;
    r_exp_q.push_back(t);
    s_araddr = addr; s_arvalid = 1'b1; n = 0;
    while (s_arvalid && n < 50) begin
      @(negedge clk);
      ar_ok = s_arready;
      @(posedge clk); #1;
      if (ar_ok) s_arvalid = 1'b0;
      n++;
    end
    s_arvalid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_rvalid && s_rready) && n < 50);
    @(posedge clk); #1;
    check("r_arrived", 64'(n < 50), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {53'd0, s_awready, s_wready, s_bvalid, s_bresp, s_arready,
                          s_rvalid, s_rresp, cell_wready, ising_rstn}, 64'd0);
    check({tag, "_data"}, {s_rdata, cell_wdata}, 64'd0);
    check({tag, "_match"}, cell_wr_addr_match, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NC; k++) cell_rdata[32*k +: 32] = exp_slice(k);
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    axi_rstn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {61'd0, s_awready, s_wready, s_arready}, 64'd7);

    // Basic weight program and read-back of cell 10.
    axi_write(12'h128, 32'd3, OKAY, 1'b1);
    axi_read(12'h128, exp_slice(10), exp_slice(10), OKAY);

    // Error responses: out-of-range weight, read-only RUNCNT, unmapped address.
    axi_write(12'h100, 32'd15, SLVERR, 1'b0);
    axi_write(12'h004, 32'd5, SLVERR, 1'b0);
    axi_write(12'h0F0, 32'd1, SLVERR, 1'b0);
    axi_read(12'h0F0, 32'd0, 32'd0, SLVERR);

    // W leads AW by 3 cycles, B back-pressured: highest weight to the last cell.
    begin
      sexp_t t;
      t.idx = 63; t.data = 32'd14;
      s_exp_q.push_back(t);
      b_exp_q.push_back(OKAY);
      s_bready = 1'b0;
      s_wdata = 32'd14; s_wvalid = 1'b1;
      @(posedge clk); #1;
      s_wvalid = 1'b0;
      check("w_first_wready_low", {63'd0, s_wready}, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      s_awaddr = 12'h1FC; s_awvalid = 1'b1;
      @(posedge clk); #1;
      s_awvalid = 1'b0;
      for (int i = 0; i < 7; i++) begin
        @(posedge clk); #1;
        check("readies_low_until_b", {62'd0, s_awready, s_wready}, 64'd0);
      end
      check("bvalid_held", {63'd0, s_bvalid}, 64'd1);
      s_bready = 1'b1;
      @(posedge clk); #1;
      check("readies_after_b", {62'd0, s_awready, s_wready}, 64'd3);
      repeat (3) @(posedge clk);
      #1;
    end
    axi_read(12'h000, 32'd0, 32'd0, OKAY);

    // Run counter: start, sample, blocked weight write, stop/hold, restart.
    axi_write(12'h000, 32'd1, OKAY, 1'b0);
    cyc_on = cyc;
    check("ising_rstn_on", {63'd0, ising_rstn}, 64'd1);
    repeat (99) @(posedge clk);
    #1;
    axi_read(12'h004, 32'd99, 32'd101, OKAY);
    axi_write(12'h104, 32'd2, SLVERR, 1'b0);
    axi_write(12'h000, 32'd0, OKAY, 1'b0);
    cyc_off = cyc;
    held = cyc_off - cyc_on;
    axi_read(12'h004, 32'(held - 2), 32'(held + 2), OKAY);
    repeat (50) @(posedge clk);
    #1;
    axi_read(12'h004, 32'(held - 2), 32'(held + 2), OKAY);
    axi_write(12'h000, 32'd1, OKAY, 1'b0);
    axi_read(12'h004, 32'd0, 32'd3, OKAY);

    // Same-cycle read and write of CTRL: old value first, new value after.
    fork
      axi_write(12'h000, 32'd0, OKAY, 1'b0);
      axi_read(12'h000, 32'd1, 32'd1, OKAY);
    join
    axi_read(12'h000, 32'd0, 32'd0, OKAY);

    // Reset during EXEC: strobe is dropped and no response follows.
    send_aw_w(12'h130, 32'd4);
    @(posedge clk); #1;
    check("exec_strobe_visible", {63'd0, cell_wready}, 64'd1);
    axi_rstn = 1'b0;
    #1;
    check_all_zero("rst_exec");
    @(posedge clk); #1;
    axi_rstn = 1'b1;
    @(posedge clk); #1;

    // Reset with a CTRL write's B pending: oscillator control returns to hold.
    s_bready = 1'b0;
    send_aw_w(12'h000, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("b_pending", {62'd0, s_bvalid, ising_rstn}, 64'd3);
    axi_rstn = 1'b0;
    #1;
    check_all_zero("rst_bpend");
    s_bready = 1'b1;
    @(posedge clk); #1;
    axi_rstn = 1'b1;
    @(posedge clk); #1;

    axi_read(12'h004, 32'd0, 32'd0, OKAY);
    axi_write(12'h150, 32'd0, OKAY, 1'b1);
    axi_read(12'h150, exp_slice(20), exp_slice(20), OKAY);
    repeat (4) @(posedge clk);
    #1;

    check("strobe_q_empty", 64'(s_exp_q.size()), 64'd0);
    check("b_q_empty", 64'(b_exp_q.size()), 64'd0);
    check("r_q_empty", 64'(r_exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
